gf32_mul_share_arb: RTL and testbench

- Shares one external GF32 multiplier (`o_start_mul`/`i_done_mul` pulse interface) among N_REQ requesters. Requesters are instances such as `r_pow_i_x_t` exponent engines built with GF32_MUL_SHARED.
- Latches pulse-style requests, grants them round-robin and forwards operands, one operation in flight at a time.
- Returns the product with a per-requester done pulse.
- Sits at the top level between the evaluate/exponent blocks and the single multiplier instance.

---
 rtl/gf32_mul_share_arb_pkg.sv | 22 ++
 rtl/gf32_mul_share_arb_rr_pick.sv | 52 +++++
 rtl/gf32_mul_share_arb.sv | 161 ++++++++++++++++
 tb/tb_gf32_mul_share_arb.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gf32_mul_share_arb_pkg.sv
// -----------------------------------------------------------------------------
// gf32_mul_share_arb_pkg
// Shared definitions for the GF32 multiplier sharing arbiter and its helpers.
//   - state_t     : arbiter FSM state encodings
//   - GF32_WIDTH  : natural operand/product width of the GF32 datapath
//   - `CLOG2      : index-width helper used for pointer/grant registers
// -----------------------------------------------------------------------------
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

package gf32_mul_share_arb_pkg;

    localparam int GF32_WIDTH = 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

endpackage

// File: rtl/gf32_mul_share_arb_rr_pick.sv
// -----------------------------------------------------------------------------
// gf32_mul_share_arb_rr_pick
// Combinational round-robin priority picker. Returns the first set bit of req
// found by searching ptr, ptr+1, ... modulo N. N need not be a power of two.
// Ports:
//   req   in  N   request vector
//   ptr   in  IW  search start index (expected < N)
//   idx   out IW  selected index (0 when nothing is requested)
//   valid out 1   any request present
// -----------------------------------------------------------------------------
module gf32_mul_share_arb_rr_pick #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          valid
);

    // (p + off) mod N, valid for p < N and off < N
    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] p, input int unsigned off);
        int unsigned s;
        s = int'(p) + off;
        if (s >= N) begin
            s = s - N;
        end
        return IW'(s);
    endfunction

    logic [IW-1:0] cand [N];
    logic [N-1:0]  hit;

    // cand[gi] is the requester sitting gi places after the pointer
    for (genvar gi = 0; gi < N; gi++) begin : g_cand
        assign cand[gi] = wrap_add(ptr, gi);
        assign hit[gi]  = req[cand[gi]];
    end

    // Walk from the far end so the candidate closest to ptr wins
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (hit[i]) begin
                idx = cand[i];
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/gf32_mul_share_arb.sv
// -----------------------------------------------------------------------------
// gf32_mul_share_arb
// Shares one external GF32 multiplier (start/done pulse interface) among N_REQ
// requesters. Pulse requests are latched with their operands, granted
// round-robin one at a time, and each result is returned with a one-hot done
// pulse while the product is broadcast on o_req_out.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_req_start [N]       per-requester one-cycle request pulse
//   i_req_x/y   [W*N]     per-requester operands, slice k = [W*k +: W]
//   o_req_out   [W]       last product, held until the next completion
//   o_req_done  [N]       one-hot one-cycle completion pulse
//   o_start_mul           one-cycle start to the multiplier
//   o_x_mul/o_y_mul [W]   operands to the multiplier, stable while in service
//   i_o_mul [W], i_done_mul  multiplier product and completion pulse
//   o_busy                any request pending or in service
//   o_err                 sticky protocol-violation flag
// -----------------------------------------------------------------------------
module gf32_mul_share_arb
    import gf32_mul_share_arb_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int WIDTH = GF32_WIDTH
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [N_REQ-1:0]       i_req_start,
    input  logic [WIDTH*N_REQ-1:0] i_req_x,
    input  logic [WIDTH*N_REQ-1:0] i_req_y,
    output logic [WIDTH-1:0]       o_req_out,
    output logic [N_REQ-1:0]       o_req_done,
    output logic                   o_start_mul,
    output logic [WIDTH-1:0]       o_x_mul,
    output logic [WIDTH-1:0]       o_y_mul,
    input  logic [WIDTH-1:0]       i_o_mul,
    input  logic                   i_done_mul,
    output logic                   o_busy,
    output logic                   o_err
);

    localparam int PTR_W = `CLOG2(N_REQ);

    state_t           state_reg, state_next;
    logic [N_REQ-1:0] pending_reg, pending_next;
    logic [PTR_W-1:0] rr_ptr_reg;
    logic [PTR_W-1:0] grant_reg;
    logic [WIDTH-1:0] x_mul_reg, y_mul_reg;
    logic [WIDTH-1:0] out_reg;
    logic [N_REQ-1:0] done_reg;
    logic             err_reg, err_next;

    logic [WIDTH-1:0] opx_reg [N_REQ];
    logic [WIDTH-1:0] opy_reg [N_REQ];

    logic [N_REQ-1:0] set_req, clr_req, viol;
    logic [PTR_W-1:0] pick_idx;
    logic             pick_valid;
    logic             take, complete;

    gf32_mul_share_arb_rr_pick #(
        .N  (N_REQ),
        .IW (PTR_W)
    ) u_pick (
        .req   (pending_reg),
        .ptr   (rr_ptr_reg),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // A start while already pending (including the completion cycle, when
    // pending is still set) is dropped and flagged.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
        assign set_req[gi] = i_req_start[gi] & ~pending_reg[gi];
        assign viol[gi]    = i_req_start[gi] &  pending_reg[gi];
        assign clr_req[gi] = complete & (grant_reg == PTR_W'(gi));
    end

    assign pending_next = (pending_reg & ~clr_req) | set_req;

    always_comb begin
        state_next = state_reg;
        take       = 1'b0;
        complete   = 1'b0;
        err_next   = err_reg | (|viol);
        unique case (state_reg)
            S_IDLE: begin
                // Hold arbitration during the done-pulse cycle: gives a fixed
                // 3-cycle done-to-start turnaround and lets the requester that
                // just finished re-request before the next pick.
                if (pick_valid && !(|done_reg)) begin
                    take       = 1'b1;
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (i_done_mul) begin
                    complete   = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        // A completion outside S_WAIT has no owner
        if (i_done_mul && state_reg != S_WAIT) begin
            err_next = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg   <= S_IDLE;
            pending_reg <= '0;
            rr_ptr_reg  <= '0;
            grant_reg   <= '0;
            x_mul_reg   <= '0;
            y_mul_reg   <= '0;
            out_reg     <= '0;
            done_reg    <= '0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pending_reg <= pending_next;
            err_reg     <= err_next;
            done_reg    <= '0;
            if (take) begin
                grant_reg <= pick_idx;
                x_mul_reg <= opx_reg[pick_idx];
                y_mul_reg <= opy_reg[pick_idx];
            end
            if (complete) begin
                out_reg    <= i_o_mul;
                done_reg   <= N_REQ'(1) << grant_reg;
                rr_ptr_reg <= (grant_reg == PTR_W'(N_REQ - 1)) ? '0 : grant_reg + PTR_W'(1);
            end
        end
    end

    // Operand slots carry no reset: a slot is read only after a capture
    always_ff @(posedge i_clk) begin
        for (int k = 0; k < N_REQ; k++) begin
            if (set_req[k]) begin
                opx_reg[k] <= i_req_x[WIDTH*k +: WIDTH];
                opy_reg[k] <= i_req_y[WIDTH*k +: WIDTH];
            end
        end
    end

    assign o_start_mul = (state_reg == S_ISSUE);
    assign o_x_mul     = x_mul_reg;
    assign o_y_mul     = y_mul_reg;
    assign o_req_out   = out_reg;
    assign o_req_done  = done_reg;
    assign o_err       = err_reg;
    assign o_busy      = (|pending_reg) | (state_reg != S_IDLE);

endmodule

// File: tb/tb_gf32_mul_share_arb.sv
// -----------------------------------------------------------------------------
// tb_gf32_mul_share_arb
// Directed bench for gf32_mul_share_arb (N_REQ=3, WIDTH=32). Stimulus pushes
// the expected (requester, product) pairs into a scoreboard queue in the
// order they must be served; a monitor pops and compares on every done pulse.
// The multiplier model returns x XOR y with i_done_mul asserted in the fourth
// cycle after the o_start_mul cycle (three idle cycles in between).
// -----------------------------------------------------------------------------
module tb_gf32_mul_share_arb;

    localparam int N   = 3;
    localparam int W   = 32;
    localparam int GAP = 4;

    logic           i_clk = 1'b0;
    logic           i_rst;
    logic [N-1:0]   i_req_start;
    logic [W*N-1:0] i_req_x, i_req_y;
    logic [W-1:0]   o_req_out;
    logic [N-1:0]   o_req_done;
    logic           o_start_mul;
    logic [W-1:0]   o_x_mul, o_y_mul;
    logic [W-1:0]   i_o_mul;
    logic           i_done_mul;
    logic           o_busy, o_err;

    always #5 i_clk = ~i_clk;

    gf32_mul_share_arb #(.N_REQ(N), .WIDTH(W)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req_start (i_req_start),
        .i_req_x     (i_req_x),
        .i_req_y     (i_req_y),
        .o_req_out   (o_req_out),
        .o_req_done  (o_req_done),
        .o_start_mul (o_start_mul),
        .o_x_mul     (o_x_mul),
        .o_y_mul     (o_y_mul),
        .i_o_mul     (i_o_mul),
        .i_done_mul  (i_done_mul),
        .o_busy      (o_busy),
        .o_err       (o_err)
    );

    typedef struct {
        int         idx;
        logic [W-1:0] val;
    } exp_t;

    exp_t       sb_q[$];
    int         done_log[$];
    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    int         n_done = 0;
    int         last_mul_done = -10;
    logic       stray_req = 1'b0;
    logic [W-1:0] xs [N];
    logic [W-1:0] ys [N];

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Multiplier model, shares i_rst with the DUT
    initial begin
        int           cnt;
        logic [W-1:0] prod;
        cnt = 0;
        prod = '0;
        i_done_mul = 1'b0;
        i_o_mul = '0;
        forever begin
            @(negedge i_clk);
            i_done_mul = 1'b0;
            if (i_rst) begin
                cnt = 0;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    i_done_mul = 1'b1;
                    i_o_mul = prod;
                    last_mul_done = cyc;
                end
            end
            if (o_start_mul && !i_rst) begin
                prod = o_x_mul ^ o_y_mul;
                cnt = GAP;
            end
            if (stray_req) begin
                i_done_mul = 1'b1;
                i_o_mul = 32'hDEAD_BEEF;
                stray_req = 1'b0;
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        exp_t         e;
        logic [N-1:0] oh;
        forever begin
            @(negedge i_clk);
            if (o_req_done != '0) begin
                n_done++;
                done_log.push_back(cyc);
                check("done_latency", cyc, last_mul_done + 1);
                if (sb_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: got done=%b out=%0h, expected no done", o_req_done, o_req_out);
                end else begin
                    e = sb_q.pop_front();
                    oh = '0;
                    oh[e.idx] = 1'b1;
                    check("done_onehot", o_req_done, oh);
                    check("done_value", o_req_out, e.val);
                end
            end
        end
    end

    task automatic pack_ops();
        for (int k = 0; k < N; k++) begin
            i_req_x[W*k +: W] = xs[k];
            i_req_y[W*k +: W] = ys[k];
        end
    endtask

    task automatic push_exp(input int k, input logic [W-1:0] v);
        exp_t e;
        e.idx = k;
        e.val = v;
        sb_q.push_back(e);
    endtask

    // Issue mask in cycle t; returns at cycle t+1 just after the edge
    task automatic pulse(input logic [N-1:0] m);
        @(posedge i_clk); #1;
        pack_ops();
        i_req_start = m;
        @(posedge i_clk); #1;
        i_req_start = '0;
    endtask

    task automatic do_reset();
        @(posedge i_clk); #1;
        i_rst = 1'b1;
        i_req_start = '0;
        stray_req = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        sb_q.delete();
        @(negedge i_clk);
        check("rst_done", o_req_done, 0);
        check("rst_out", o_req_out, 0);
        check("rst_start", o_start_mul, 0);
        check("rst_x", o_x_mul, 0);
        check("rst_y", o_y_mul, 0);
        check("rst_err", o_err, 0);
        check("rst_busy", o_busy, 0);
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        do begin
            @(negedge i_clk); #1;
            n++;
        end while ((o_busy || sb_q.size() != 0) && n < bound);
        check("idle_reached", {o_busy, sb_q.size() != 0}, 0);
    endtask

    // Wait for requester k's done, then re-request in that same cycle
    task automatic wait_done_pulse(input int k, input logic [W-1:0] x, input logic [W-1:0] y);
        logic seen;
        seen = 1'b0;
        for (int n = 0; n < 60 && !seen; n++) begin
            @(negedge i_clk);
            if (o_req_done[k]) seen = 1'b1;
        end
        check("wait_done_seen", seen, 1);
        xs[k] = x;
        ys[k] = y;
        pack_ops();
        i_req_start = '0;
        i_req_start[k] = 1'b1;
        push_exp(k, x ^ y);
        @(posedge i_clk); #1;
        i_req_start = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap;
        i_rst = 1'b1;
        i_req_start = '0;
        i_req_x = '0;
        i_req_y = '0;
        for (int k = 0; k < N; k++) begin
            xs[k] = '0;
            ys[k] = '0;
        end
        do_reset();

        // Single request from requester 1
        $display("[TB] single request");
        xs[1] = 32'h1234_5678;
        ys[1] = 32'h0F0F_0F0F;
        push_exp(1, 32'h1D3B_5977);
        snap = n_done;
        pulse(3'b010);
        @(negedge i_clk);
        check("single_start_t1", o_start_mul, 0);
        @(negedge i_clk);
        check("single_start_t2", o_start_mul, 1);
        check("single_x", o_x_mul, 32'h1234_5678);
        check("single_y", o_y_mul, 32'h0F0F_0F0F);
        wait_idle(40);
        repeat (3) @(negedge i_clk);
        check("single_busy_low", o_busy, 0);
        check("single_out_held", o_req_out, 32'h1D3B_5977);
        check("single_n_done", n_done - snap, 1);

        // Three simultaneous requests
        $display("[TB] simultaneous three");
        do_reset();
        for (int k = 0; k < N; k++) begin
            xs[k] = k + 1;
            ys[k] = 32'h100;
        end
        push_exp(0, 32'h101);
        push_exp(1, 32'h102);
        push_exp(2, 32'h103);
        done_log.delete();
        pulse(3'b111);
        wait_idle(100);
        check("sim3_n_done", done_log.size(), 3);
        if (done_log.size() == 3) begin
            check("sim3_gap01", done_log[1] - done_log[0], 7);
            check("sim3_gap12", done_log[2] - done_log[1], 7);
        end

        // Fairness: 0 re-requests as soon as it completes while 2 pends
        $display("[TB] fairness");
        do_reset();
        xs[0] = 32'hA0; ys[0] = 32'h01;
        xs[2] = 32'hC0; ys[2] = 32'h02;
        push_exp(0, 32'hA1);
        push_exp(2, 32'hC2);
        pulse(3'b101);
        wait_done_pulse(0, 32'hB0, 32'h03);
        wait_done_pulse(2, 32'hD0, 32'h04);
        wait_idle(100);
        check("fair_err_clear", o_err, 0);

        // Double start from requester 2 before its done
        $display("[TB] protocol violation");
        do_reset();
        snap = n_done;
        xs[2] = 32'h55; ys[2] = 32'hAA;
        push_exp(2, 32'hFF);
        @(posedge i_clk); #1;
        pack_ops();
        i_req_start = 3'b100;
        @(posedge i_clk); #1;
        xs[2] = 32'h11; ys[2] = 32'h22;
        pack_ops();
        i_req_start = 3'b100;
        @(posedge i_clk); #1;
        i_req_start = '0;
        @(negedge i_clk);
        check("viol_err_set", o_err, 1);
        wait_idle(60);
        repeat (4) @(negedge i_clk);
        check("viol_err_sticky", o_err, 1);
        check("viol_n_done", n_done - snap, 1);

        // Stray multiplier done while idle
        $display("[TB] stray done");
        do_reset();
        snap = n_done;
        @(posedge i_clk); #1;
        stray_req = 1'b1;
        repeat (4) @(negedge i_clk);
        check("stray_err", o_err, 1);
        check("stray_busy", o_busy, 0);
        check("stray_out", o_req_out, 0);
        check("stray_n_done", n_done - snap, 0);

        // Reset during S_WAIT with two pending
        $display("[TB] reset mid-operation");
        do_reset();
        xs[0] = 32'h7; ys[0] = 32'h8;
        push_exp(0, 32'hF);
        pulse(3'b001);
        wait_idle(40);
        xs[0] = 32'h1; ys[0] = 32'h2;
        xs[1] = 32'h3; ys[1] = 32'h4;
        pulse(3'b011);
        @(posedge i_clk); #1;
        @(posedge i_clk); #1;
        check("mid_busy_before", o_busy, 1);
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        check("mid_done", o_req_done, 0);
        check("mid_out", o_req_out, 0);
        check("mid_start", o_start_mul, 0);
        check("mid_x", o_x_mul, 0);
        check("mid_y", o_y_mul, 0);
        check("mid_err", o_err, 0);
        check("mid_busy", o_busy, 0);
        snap = n_done;
        repeat (12) @(negedge i_clk);
        check("mid_no_done", n_done - snap, 0);
        xs[0] = 32'h100; ys[0] = 32'h001;
        xs[2] = 32'h200; ys[2] = 32'h002;
        push_exp(0, 32'h101);
        push_exp(2, 32'h202);
        pulse(3'b101);
        wait_idle(80);
        check("mid_after_n_done", n_done - snap, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
